// File: rtl/ama_riscv_if_id_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop side, pre-decoded immediate controls.
// master = fetch/decode environment, slave = the queue.
interface ama_riscv_if_id_queue_if #(
  parameter int DEPTH = 2
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_inst;
  logic [31:0]               in_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_inst;
  logic [31:0]               out_pc;
  logic [24:0]               ig_in;
  logic [3:0]                ig_sel;
  logic                      ig_en;
  logic                      out_illegal;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, ig_in, ig_sel, ig_en, out_illegal, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, ig_in, ig_sel, ig_en, out_illegal, count
  );
endinterface

// File: rtl/ama_riscv_if_id_queue.sv
// IF/ID instruction queue: circular buffer that stores each instruction with its PC and
// its immediate format, decoded once at push so decode sees it straight from storage.
module ama_riscv_if_id_queue #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  ama_riscv_if_id_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [3:0]  IG_I_TYPE = 4'd0;
  localparam logic [3:0]  IG_S_TYPE = 4'd1;
  localparam logic [3:0]  IG_B_TYPE = 4'd2;
  localparam logic [3:0]  IG_J_TYPE = 4'd3;
  localparam logic [3:0]  IG_U_TYPE = 4'd4;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef struct packed {
    logic [3:0] sel;
    logic       en;
    logic       illegal;
  } predec_t;

  // Full 7-bit opcode match, so inst[1:0] != 2'b11 also falls into the illegal default.
  function automatic predec_t predecode(input logic [6:0] opcode);
    predec_t d;
    d.sel     = IG_I_TYPE;
    d.en      = 1'b0;
    d.illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: d.en = 1'b1;
      7'b0100011: begin d.sel = IG_S_TYPE; d.en = 1'b1; end
      7'b1100011: begin d.sel = IG_B_TYPE; d.en = 1'b1; end
      7'b1101111: begin d.sel = IG_J_TYPE; d.en = 1'b1; end
      7'b0110111, 7'b0010111: begin d.sel = IG_U_TYPE; d.en = 1'b1; end
      7'b0110011, 7'b0001111: d.en = 1'b0;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  logic [31:0]      inst_mem_r [DEPTH];
  logic [31:0]      pc_mem_r   [DEPTH];
  predec_t          dec_mem_r  [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;

  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      out_inst_s;
  logic [31:0]      out_pc_s;
  predec_t          out_dec_s;

  // in_ready looks only at occupancy and reset, never at out_ready.
  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  assign q.in_ready  = !rst && (count_r < DEPTH_C);
  assign push_s      = q.in_valid && q.in_ready;
  assign pop_s       = out_valid_s && q.out_ready;

  // Pointer and occupancy update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (q.flush) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wptr_r <= wptr_r + PTR_W'(1);
      if (pop_s)  rptr_r <= rptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents survive flush and reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s && !q.flush) begin
      inst_mem_r[wptr_r] <= q.in_inst;
      pc_mem_r[wptr_r]   <= q.in_pc;
      dec_mem_r[wptr_r]  <= predecode(q.in_inst[6:0]);
    end
  end

  // Head selection, with NOP defaults whenever the queue is empty.
  always_comb begin
    out_inst_s        = NOP_INST;
    out_pc_s          = 32'h0000_0000;
    out_dec_s.sel     = IG_I_TYPE;
    out_dec_s.en      = 1'b0;
    out_dec_s.illegal = 1'b0;
    if (out_valid_s) begin
      out_inst_s = inst_mem_r[rptr_r];
      out_pc_s   = pc_mem_r[rptr_r];
      out_dec_s  = dec_mem_r[rptr_r];
    end else begin
      out_inst_s = NOP_INST;
    end
  end

  assign q.out_valid   = out_valid_s;
  assign q.out_inst    = out_inst_s;
  assign q.out_pc      = out_pc_s;
  assign q.ig_in       = out_inst_s[31:7];
  assign q.ig_sel      = out_dec_s.sel;
  assign q.ig_en       = out_dec_s.en;
  assign q.out_illegal = out_dec_s.illegal;
  assign q.count       = count_r;
endmodule

// File: tb/tb_ama_riscv_if_id_queue.sv
// Directed bench for ama_riscv_if_id_queue (DEPTH=2) with hand-computed expectations.
module tb_ama_riscv_if_id_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  ama_riscv_if_id_queue_if #(.DEPTH(2)) bus ();
  ama_riscv_if_id_queue #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .q(bus));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    total++;
    assert (obs === expd) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expd);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  logic [31:0] stream_inst [3];
  logic [3:0]  stream_sel  [3];
  logic        stream_en   [3];

  initial begin
    stream_inst[0] = 32'h0080_00EF; stream_sel[0] = 4'd3; stream_en[0] = 1'b1;
    stream_inst[1] = 32'h1234_50B7; stream_sel[1] = 4'd4; stream_en[1] = 1'b1;
    stream_inst[2] = 32'h0020_81B3; stream_sel[2] = 4'd0; stream_en[2] = 1'b0;

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst",  bus.out_inst,       32'h0000_0013);
    check("rst_count",     32'(bus.count),     32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // ADDI x1, x0, 5
    tick();
    drive(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("addi_valid",   32'(bus.out_valid),   32'd1);
    check("addi_sel",     32'(bus.ig_sel),      32'd0);
    check("addi_en",      32'(bus.ig_en),       32'd1);
    check("addi_ig_in",   32'(bus.ig_in),       32'h0000_A001);
    check("addi_count",   32'(bus.count),       32'd1);
    check("addi_illegal", 32'(bus.out_illegal), 32'd0);
    check("addi_pc",      bus.out_pc,           32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("addi_pop_count", 32'(bus.count),     32'd0);
    check("addi_pop_valid", 32'(bus.out_valid), 32'd0);

    // fill with SW then BEQ
    drive(1'b1, 32'h0011_2023, 32'h4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0463, 32'h8, 1'b0, 1'b0);
    tick();
    check("full_count",    32'(bus.count),    32'd2);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 32'hC, 1'b0, 1'b0);
    tick();
    check("refused_count", 32'(bus.count), 32'd2);
    check("head_sw_inst",  bus.out_inst,   32'h0011_2023);
    check("head_sw_sel",   32'(bus.ig_sel), 32'd1);
    check("head_sw_en",    32'(bus.ig_en),  32'd1);
    check("head_sw_pc",    bus.out_pc,      32'h4);
    // full: push refused even with a same-cycle pop
    drive(1'b1, 32'hFFFF_FFFF, 32'hC, 1'b1, 1'b0);
    tick();
    check("full_pop_count", 32'(bus.count), 32'd1);
    check("head_beq_sel",   32'(bus.ig_sel), 32'd2);
    check("head_beq_inst",  bus.out_inst,    32'h0000_0463);
    check("head_beq_pc",    bus.out_pc,      32'h8);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("drain_count", 32'(bus.count), 32'd0);

    // stream with out_ready held high, 9 pushes so both pointers wrap several times
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, stream_inst[i % 3], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      check("stream_inst",  bus.out_inst,       stream_inst[i % 3]);
      check("stream_pc",    bus.out_pc,         32'h200 + 32'(4 * i));
      check("stream_sel",   32'(bus.ig_sel),    32'(stream_sel[i % 3]));
      check("stream_en",    32'(bus.ig_en),     32'(stream_en[i % 3]));
      check("stream_count", 32'(bus.count),     32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("stream_end_count", 32'(bus.count), 32'd0);

    // flush while full with push and pop requested
    drive(1'b1, 32'h00A0_0113, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00A0_0113, 32'h304, 1'b0, 1'b0);
    tick();
    check("pre_flush_count", 32'(bus.count), 32'd2);
    drive(1'b1, 32'h0000_0463, 32'h308, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_count", 32'(bus.count),     32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_inst",  bus.out_inst,       32'h0000_0013);
    check("flush_pc",    bus.out_pc,         32'h0);
    check("flush_en",    32'(bus.ig_en),     32'd0);
    drive(1'b1, 32'h0011_2023, 32'h400, 1'b0, 1'b0);
    tick();
    check("post_flush_inst", bus.out_inst,   32'h0011_2023);
    check("post_flush_pc",   bus.out_pc,     32'h400);
    check("post_flush_cnt",  32'(bus.count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // illegal encodings
    drive(1'b1, 32'hFFFF_FFFF, 32'h500, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0000, 32'h504, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ill_ff_illegal", 32'(bus.out_illegal), 32'd1);
    check("ill_ff_en",      32'(bus.ig_en),       32'd0);
    check("ill_ff_sel",     32'(bus.ig_sel),      32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("ill_00_illegal", 32'(bus.out_illegal), 32'd1);
    check("ill_00_en",      32'(bus.ig_en),       32'd0);
    check("ill_00_inst",    bus.out_inst,         32'h0);
    tick();
    check("ill_drained", 32'(bus.count), 32'd0);

    // asynchronous reset while holding two entries
    drive(1'b1, 32'h0050_0093, 32'h600, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid",    32'(bus.out_valid), 32'd0);
    check("async_in_ready", 32'(bus.in_ready),  32'd0);
    check("async_count",    32'(bus.count),     32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("post_rst_count", 32'(bus.count),     32'd0);
    check("post_rst_inst",  bus.out_inst,       32'h0000_0013);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
